id_ex_stage: RTL

Decode/execute boundary register for the RV32I core. Takes a fetched instruction with its register-file read data and produces the registered operand pair and control word (`A`, `B`, `operation`, `switch`) the ALU consumes in the following stage. Operand forwarding from the MEM and WB stages is applied at capture time. A valid/ready handshake on both sides provides back-pressure, and a flush input kills wrong-path instructions.

---
 rtl/id_ex_stage.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   Decode/execute boundary register for the RV32I core. It decodes the
//   incoming instruction, resolves operand bypassing from the MEM and WB
//   stages, and registers the ALU operand pair plus control word for the
//   execute stage. It has a valid/ready handshake on both sides and a flush
//   input that kills wrong-path instructions.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        upstream handshake
//   instr, pc                  instruction word and its address
//   rs1_data, rs2_data         register-file reads for instr[19:15] / [24:20]
//   fwd_mem_en/_rd/_data       pending MEM-stage write (highest priority)
//   fwd_wb_en/_rd/_data        pending WB-stage write
//   flush                      kill the held and the incoming instruction
//   out_valid / out_ready      downstream handshake
//   out_a, out_b               ALU operands
//   out_operation, out_switch  ALU function select, SUB/SRA modifier
//   out_rd, out_we             destination register and write enable
//   out_pc                     copy of pc
//   out_branch, out_funct3     conditional branch and its condition code
//   out_illegal                unsupported or invalid encoding
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        fwd_mem_en,
  input  logic [4:0]  fwd_mem_rd,
  input  logic [31:0] fwd_mem_data,
  input  logic        fwd_wb_en,
  input  logic [4:0]  fwd_wb_rd,
  input  logic [31:0] fwd_wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [2:0]  out_operation,
  output logic        out_switch,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic [31:0] out_pc,
  output logic        out_branch,
  output logic [2:0]  out_funct3,
  output logic        out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rs1_idx;
  logic [4:0]  w_rs2_idx;
  logic [4:0]  w_rd;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_u;
  logic [31:0] w_shamt;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [2:0]  w_op;
  logic        w_sw;
  logic        w_br_raw;
  logic        w_illegal;
  logic        w_branch;
  logic        w_we;
  logic        w_capture;

  logic        r_valid;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [2:0]  r_op;
  logic        r_sw;
  logic [4:0]  r_rd;
  logic        r_we;
  logic [31:0] r_pc;
  logic        r_branch;
  logic [2:0]  r_funct3;
  logic        r_illegal;

  assign w_opcode  = instr[6:0];
  assign w_rd      = instr[11:7];
  assign w_funct3  = instr[14:12];
  assign w_rs1_idx = instr[19:15];
  assign w_rs2_idx = instr[24:20];
  assign w_funct7  = instr[31:25];
  assign w_imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign w_imm_u   = {instr[31:12], 12'b0};
  // Shift-immediates carry funct7 in the upper immediate bits, so the ALU
  // is handed the bare shift amount instead of the sign-extended I-imm.
  assign w_shamt   = {27'b0, instr[24:20]};

  // x0 is hardwired; otherwise the youngest pending write (MEM) wins.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  idx,
    input logic [31:0] rf,
    input logic        mem_en,
    input logic [4:0]  mem_rd,
    input logic [31:0] mem_data,
    input logic        wb_en,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_data
  );
    logic [31:0] val;
    if (idx == 5'd0)                       val = 32'd0;
    else if (mem_en && (mem_rd == idx))    val = mem_data;
    else if (wb_en && (wb_rd == idx))      val = wb_data;
    else                                   val = rf;
    return val;
  endfunction

  assign w_rs1_val = fwd_sel(w_rs1_idx, rs1_data, fwd_mem_en, fwd_mem_rd, fwd_mem_data,
                             fwd_wb_en, fwd_wb_rd, fwd_wb_data);
  assign w_rs2_val = fwd_sel(w_rs2_idx, rs2_data, fwd_mem_en, fwd_mem_rd, fwd_mem_data,
                             fwd_wb_en, fwd_wb_rd, fwd_wb_data);

  always_comb begin
    w_a       = 32'd0;
    w_b       = 32'd0;
    w_op      = 3'b000;
    w_sw      = 1'b0;
    w_br_raw  = 1'b0;
    w_illegal = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_a  = w_rs1_val;
        w_b  = w_rs2_val;
        w_op = w_funct3;
        if ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)) begin
          w_sw      = instr[30];
          w_illegal = (w_funct7 != 7'd0) && (w_funct7 != F7_ALT);
        end else begin
          w_illegal = (w_funct7 != 7'd0);
        end
      end
      OPC_OP_IMM: begin
        w_a  = w_rs1_val;
        w_op = w_funct3;
        case (w_funct3)
          3'b001: begin
            w_b       = w_shamt;
            w_illegal = (w_funct7 != 7'd0);
          end
          3'b101: begin
            w_b       = w_shamt;
            w_sw      = instr[30];
            w_illegal = (w_funct7 != 7'd0) && (w_funct7 != F7_ALT);
          end
          default: w_b = w_imm_i;
        endcase
      end
      OPC_LUI: begin
        w_b = w_imm_u;
      end
      OPC_AUIPC: begin
        w_a = pc;
        w_b = w_imm_u;
      end
      OPC_BRANCH: begin
        w_a       = w_rs1_val;
        w_b       = w_rs2_val;
        w_sw      = 1'b1;
        w_br_raw  = 1'b1;
        w_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_branch  = w_br_raw && !w_illegal;
  assign w_we      = !w_illegal && !w_br_raw && (w_rd != 5'd0);

  assign in_ready  = !r_valid || out_ready;
  assign w_capture = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_op      <= 3'd0;
      r_sw      <= 1'b0;
      r_rd      <= 5'd0;
      r_we      <= 1'b0;
      r_pc      <= 32'd0;
      r_branch  <= 1'b0;
      r_funct3  <= 3'd0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      // Data registers keep stale contents; they are ignored while invalid.
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid   <= 1'b1;
      r_a       <= w_a;
      r_b       <= w_b;
      r_op      <= w_op;
      r_sw      <= w_sw;
      r_rd      <= w_rd;
      r_we      <= w_we;
      r_pc      <= pc;
      r_branch  <= w_branch;
      r_funct3  <= w_funct3;
      r_illegal <= w_illegal;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid     = r_valid;
  assign out_a         = r_a;
  assign out_b         = r_b;
  assign out_operation = r_op;
  assign out_switch    = r_sw;
  assign out_rd        = r_rd;
  assign out_we        = r_we;
  assign out_pc        = r_pc;
  assign out_branch    = r_branch;
  assign out_funct3    = r_funct3;
  assign out_illegal   = r_illegal;

endmodule
